// File: rtl/core_trace_pkg.sv
// Shared types for the trace recorder: FSM state, entry kind and fixed widths.
package core_trace_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    POST  = 2'd2,
    READ  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    IFETCH = 2'd0,
    DLOAD  = 2'd1,
    DSTORE = 2'd2
  } kind_t;

  localparam int unsigned KindW = 2;
  localparam int unsigned DropW = 16;

  function automatic int unsigned entry_width(int unsigned addr_w, int unsigned data_w);
    return KindW + addr_w + data_w;
  endfunction

endpackage

// File: rtl/trace_ring.sv
// Circular trace store: write pointer wraps, entries saturates at Depth, and the
// read side replays the held entries oldest-first.
module trace_ring #(
  parameter int unsigned Width = 66,
  parameter int unsigned Depth = 8,
  parameter int unsigned CntW  = $clog2(Depth) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             wr_en_i,
  input  logic [Width-1:0] wr_data_i,
  input  logic             rd_load_i,
  input  logic             rd_adv_i,
  output logic [Width-1:0] rd_data_o,
  output logic             rd_last_o,
  output logic [CntW-1:0]  entries_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  entries_q, entries_d, rd_left_q, rd_left_d;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    entries_d = entries_q;
    if (clear_i) begin
      wr_ptr_d  = '0;
      entries_d = '0;
    end else if (wr_en_i) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      if (entries_q != CntW'(Depth)) entries_d = entries_q + 1'b1;
    end

    rd_ptr_d  = rd_ptr_q;
    rd_left_d = rd_left_q;
    // Load from next-state values so the final capture write is included.
    if (rd_load_i) begin
      rd_ptr_d  = wr_ptr_d - entries_d[PtrW-1:0];
      rd_left_d = entries_d;
    end else if (rd_adv_i && rd_left_q != '0) begin
      rd_ptr_d  = rd_ptr_q + 1'b1;
      rd_left_d = rd_left_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      entries_q <= '0;
      rd_left_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      entries_q <= entries_d;
      rd_left_q <= rd_left_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign rd_last_o = (rd_left_q == CntW'(1));
  assign entries_o = entries_q;

endmodule

// File: rtl/core_trace_capture.sv
// Bus trace recorder: arbitrates fetch/data captures, stops a programmed number of
// entries after an address trigger, then dumps the ring over a valid/ready port.
module core_trace_capture
  import core_trace_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned CW         = $clog2(DEPTH) + 1
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  arm,
  input  logic [1:0]            mode,
  input  logic [ADDR_WIDTH-1:0] trig_addr,
  input  logic [CW-1:0]         post_count,
  input  logic                  i_valid,
  input  logic [ADDR_WIDTH-1:0] iaddr,
  input  logic [DATA_WIDTH-1:0] idata,
  input  logic                  d_valid,
  input  logic                  d_rw,
  input  logic [ADDR_WIDTH-1:0] daddr,
  input  logic [DATA_WIDTH-1:0] ddata_w,
  input  logic [DATA_WIDTH-1:0] ddata_r,
  input  logic                  rd_ready,
  output logic                  rd_valid,
  output logic [1:0]            rd_kind,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_last,
  output logic [1:0]            state,
  output logic                  triggered,
  output logic                  done,
  output logic [CW-1:0]         entries,
  output logic [15:0]           drop_cnt
);

  typedef struct packed {
    kind_t                 kind;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  localparam int unsigned EntryW = entry_width(ADDR_WIDTH, DATA_WIDTH);

  state_t            state_q, state_d;
  logic [CW-1:0]     post_q, post_d, post_clamp;
  logic              trig_q, trig_d, done_q;
  logic [DropW-1:0]  drop_q, drop_d;
  logic              take_d, take_i, cand_valid;
  entry_t            cand, ring_entry;
  logic              wr_en, clear, rd_load, rd_adv, ring_last;
  logic [EntryW-1:0] ring_data;

  assign post_clamp = (post_count > CW'(DEPTH - 1)) ? CW'(DEPTH - 1) : post_count;

  always_comb begin
    take_d     = mode[1] & d_valid;
    take_i     = mode[0] & i_valid;
    cand_valid = take_d | take_i;
    cand.kind  = IFETCH;
    cand.addr  = iaddr;
    cand.data  = idata;
    if (take_d) begin
      cand.kind = d_rw ? DSTORE : DLOAD;
      cand.addr = daddr;
      cand.data = d_rw ? ddata_w : ddata_r;
    end
  end

  always_comb begin
    state_d = state_q;
    post_d  = post_q;
    trig_d  = trig_q;
    drop_d  = drop_q;
    clear   = 1'b0;
    wr_en   = 1'b0;
    rd_adv  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (arm) begin
          state_d = ARMED;
          clear   = 1'b1;
          trig_d  = 1'b0;
          drop_d  = '0;
        end
      end
      ARMED: begin
        wr_en = cand_valid;
        if (cand_valid && cand.addr == trig_addr) begin
          trig_d  = 1'b1;
          post_d  = post_clamp;
          state_d = (post_clamp == '0) ? READ : POST;
        end
      end
      POST: begin
        wr_en = cand_valid;
        if (cand_valid) begin
          post_d = post_q - 1'b1;
          if (post_q == CW'(1)) state_d = READ;
        end
      end
      READ: begin
        rd_adv = rd_ready;
        if (rd_ready && ring_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if ((state_q == ARMED || state_q == POST) && take_d && take_i && drop_q != 16'hFFFF) begin
      drop_d = drop_q + 1'b1;
    end
  end

  assign rd_load = (state_d == READ) && (state_q != READ);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      post_q  <= '0;
      trig_q  <= 1'b0;
      done_q  <= 1'b0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      post_q  <= post_d;
      trig_q  <= trig_d;
      done_q  <= rd_load;
      drop_q  <= drop_d;
    end
  end

  trace_ring #(
    .Width(EntryW),
    .Depth(DEPTH),
    .CntW (CW)
  ) u_ring (
    .clk_i    (CLK),
    .rst_i    (RESET),
    .clear_i  (clear),
    .wr_en_i  (wr_en),
    .wr_data_i(cand),
    .rd_load_i(rd_load),
    .rd_adv_i (rd_adv),
    .rd_data_o(ring_data),
    .rd_last_o(ring_last),
    .entries_o(entries)
  );

  assign ring_entry = entry_t'(ring_data);

  // Readout fields are forced to zero outside READ so reset shows all-zero outputs.
  assign rd_valid  = (state_q == READ);
  assign rd_kind   = rd_valid ? ring_entry.kind : 2'd0;
  assign rd_addr   = rd_valid ? ring_entry.addr : '0;
  assign rd_data   = rd_valid ? ring_entry.data : '0;
  assign rd_last   = rd_valid & ring_last;
  assign state     = state_q;
  assign triggered = trig_q;
  assign done      = done_q;
  assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_core_trace_capture.sv
// Randomised bench for core_trace_capture against a transaction-log reference model.
module tb_core_trace_capture;

  localparam int D = 8;

  logic        clk = 1'b0;
  logic        RESET = 1'b1;
  logic        arm = 1'b0;
  logic [1:0]  mode = '0;
  logic [31:0] trig_addr = '0;
  logic [3:0]  post_count = '0;
  logic        i_valid = 1'b0, d_valid = 1'b0, d_rw = 1'b0, rd_ready = 1'b0;
  logic [31:0] iaddr = '0, idata = '0, daddr = '0, ddata_w = '0, ddata_r = '0;
  logic        rd_valid, rd_last, triggered, done;
  logic [1:0]  rd_kind, state;
  logic [31:0] rd_addr, rd_data;
  logic [3:0]  entries;
  logic [15:0] drop_cnt;

  always #5 clk = ~clk;

  core_trace_capture #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(D)) dut (
    .CLK(clk), .RESET(RESET), .arm(arm), .mode(mode), .trig_addr(trig_addr),
    .post_count(post_count), .i_valid(i_valid), .iaddr(iaddr), .idata(idata),
    .d_valid(d_valid), .d_rw(d_rw), .daddr(daddr), .ddata_w(ddata_w), .ddata_r(ddata_r),
    .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_kind(rd_kind), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_last(rd_last), .state(state), .triggered(triggered),
    .done(done), .entries(entries), .drop_cnt(drop_cnt)
  );

  typedef struct {
    logic [1:0]  kind;
    logic [31:0] addr;
    logic [31:0] data;
  } ent_t;

  ent_t log_q[$];
  int   n_pass = 0;
  int   n_chk  = 0;

  task automatic check_eq(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic idle_inputs();
    i_valid = 1'b0; d_valid = 1'b0; d_rw = 1'b0; arm = 1'b0;
  endtask

  // stim: 0 random, 1 sequential fetches, 2 fetch/store conflict.
  // rdy: 0 always ready, 1 toggle, 2 random.
  task automatic run_case(string name, logic [1:0] md, logic [31:0] ta, logic [3:0] pc,
                          int stim, int rdy);
    bit   reached = 0;
    bit   m_trig = 0;
    int   remaining = 0;
    int   drops = 0;
    int   cyc = 0;
    int   n, idx, guard;
    ent_t e;
    ent_t exp_q[$];
    log_q.delete();

    @(negedge clk);
    mode = md; trig_addr = ta; post_count = pc; arm = 1'b1;
    i_valid = 1'b0; d_valid = 1'b0;
    @(negedge clk);
    arm = 1'b0;
    check_eq({name, ":armed_state"}, state, 2'd1);
    check_eq({name, ":armed_entries"}, entries, 0);
    check_eq({name, ":armed_trig"}, triggered, 0);

    while (!reached && cyc < 300) begin
      if (stim == 1) begin
        i_valid = 1'b1; d_valid = 1'b0; iaddr = cyc * 4; idata = $urandom;
      end else if (stim == 2) begin
        i_valid = 1'b1; d_valid = 1'b1; d_rw = 1'b1;
        iaddr = $urandom & 32'hFFC; daddr = 32'h100; ddata_w = 32'hDEADBEEF;
        idata = $urandom; ddata_r = $urandom;
      end else begin
        i_valid = 1'($urandom_range(0, 1)); d_valid = 1'($urandom_range(0, 1));
        d_rw = 1'($urandom_range(0, 1));
        iaddr = ($urandom_range(0, 5) == 0) ? ta : ($urandom & 32'hFC);
        daddr = ($urandom_range(0, 5) == 0) ? ta : ($urandom & 32'hFC);
        if (cyc >= 60) begin iaddr = ta; daddr = ta; end
        idata = $urandom; ddata_w = $urandom; ddata_r = $urandom;
      end

      // Reference: pick the winning transaction, log it, track trigger and countdown.
      if (md[1] && d_valid && md[0] && i_valid && drops < 65535) drops++;
      if ((md[1] && d_valid) || (md[0] && i_valid)) begin
        if (md[1] && d_valid) begin
          e.kind = d_rw ? 2'd2 : 2'd1; e.addr = daddr; e.data = d_rw ? ddata_w : ddata_r;
        end else begin
          e.kind = 2'd0; e.addr = iaddr; e.data = idata;
        end
        log_q.push_back(e);
        if (!m_trig) begin
          if (e.addr == ta) begin
            m_trig = 1;
            remaining = (pc > D - 1) ? D - 1 : int'(pc);
            if (remaining == 0) reached = 1;
          end
        end else begin
          remaining--;
          if (remaining == 0) reached = 1;
        end
      end
      cyc++;
      @(negedge clk);
    end
    idle_inputs();
    if (!reached) check_eq({name, ":no_trigger"}, 1, 0);

    n = (log_q.size() < D) ? log_q.size() : D;
    for (int k = 0; k < n; k++) exp_q.push_back(log_q[log_q.size() - n + k]);

    check_eq({name, ":read_state"}, state, 2'd3);
    check_eq({name, ":done_first"}, done, 1);
    check_eq({name, ":triggered"}, triggered, 1);
    check_eq({name, ":entries"}, entries, n);
    check_eq({name, ":drop_cnt"}, drop_cnt, drops);

    idx = 0; guard = 0;
    while (idx < n && guard < 200) begin
      check_eq({name, ":rd_valid"}, rd_valid, 1);
      check_eq({name, ":rd_kind"}, rd_kind, exp_q[idx].kind);
      check_eq({name, ":rd_addr"}, rd_addr, exp_q[idx].addr);
      check_eq({name, ":rd_data"}, rd_data, exp_q[idx].data);
      check_eq({name, ":rd_last"}, rd_last, (idx == n - 1));
      if (guard > 0) check_eq({name, ":done_once"}, done, 0);
      if (rdy == 0) rd_ready = 1'b1;
      else if (rdy == 1) rd_ready = (guard % 2 == 0);
      else rd_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (rd_ready) idx++;
      guard++;
    end
    rd_ready = 1'b0;
    if (idx < n) check_eq({name, ":read_timeout"}, idx, n);
    check_eq({name, ":end_state"}, state, 2'd0);
    check_eq({name, ":end_valid"}, rd_valid, 0);
  endtask

  initial begin
    idle_inputs();
    repeat (2) @(negedge clk);
    check_eq("rst_state", state, 0);
    check_eq("rst_valid", rd_valid, 0);
    check_eq("rst_entries", entries, 0);
    check_eq("rst_trig", triggered, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_drop", drop_cnt, 0);
    RESET = 1'b0;

    run_case("basic", 2'b01, 32'h10, 4'd2, 1, 0);
    run_case("wrap", 2'b01, 32'h40, 4'd3, 1, 0);
    run_case("conflict", 2'b11, 32'h100, 4'd4, 2, 0);
    run_case("backpr", 2'b01, 32'h10, 4'd2, 1, 1);
    run_case("clamp", 2'b01, 32'h40, 4'd15, 1, 1);
    run_case("post0", 2'b01, 32'h10, 4'd0, 1, 0);

    // Abort in POST with an asynchronous reset pulse between edges.
    @(negedge clk);
    mode = 2'b01; trig_addr = 32'h10; post_count = 4'd5; arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
    for (int c = 0; c < 6; c++) begin
      i_valid = 1'b1; iaddr = c * 4; idata = $urandom;
      @(negedge clk);
    end
    idle_inputs();
    check_eq("rstpost_pre_state", state, 2'd2);
    #2 RESET = 1'b1;
    #1;
    check_eq("rstpost_state", state, 0);
    check_eq("rstpost_valid", rd_valid, 0);
    check_eq("rstpost_entries", entries, 0);
    check_eq("rstpost_trig", triggered, 0);
    @(negedge clk);
    RESET = 1'b0;
    run_case("after_rst", 2'b01, 32'h14, 4'd3, 1, 2);

    for (int r = 0; r < 6; r++) begin
      logic [1:0] md;
      md = 2'($urandom_range(1, 3));
      run_case("rand", md, 32'h20, 4'($urandom_range(0, 15)), 0, 2);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/core_trace_capture.md
Name: core_trace_capture

Overview:
- Parametrised trace recorder for the RISC-V core bench; taps the instruction and data memory buses (iaddr/idata, daddr/ddata_w/ddata_r/d_rw).
- Records bus transactions into a circular buffer, stops a programmable number of entries after an address-match trigger, then streams the buffer out oldest-first over a valid/ready port.
- Generalises the existing passive monitor: parametrised widths and depth, selectable capture mode, trigger, and drop accounting.

Parameters:
- DATA_WIDTH, 32, width of idata/ddata_w/ddata_r and recorded data.
- ADDR_WIDTH, 32, width of iaddr/daddr and recorded address.
- DEPTH, 8, trace entries; power of two, >= 2.
- CW, $clog2(DEPTH)+1, width of post_count and entries.

Ports:
- CLK  in  1  clock.
- RESET  in  1  asynchronous, active-high reset.
- arm  in  1  one-cycle start pulse.
- mode  in  2  bit0 = capture fetches, bit1 = capture data accesses.
- trig_addr  in  ADDR_WIDTH  trigger address.
- post_count  in  CW  entries to record after the trigger entry.
- i_valid  in  1  fetch valid this cycle.
- iaddr  in  ADDR_WIDTH  fetch address.
- idata  in  DATA_WIDTH  fetched instruction.
- d_valid  in  1  data access valid this cycle.
- d_rw  in  1  1 = store, 0 = load.
- daddr  in  ADDR_WIDTH  data address.
- ddata_w  in  DATA_WIDTH  store data.
- ddata_r  in  DATA_WIDTH  load data.
- rd_ready  in  1  readout consumer ready.
- rd_valid  out  1  readout entry valid.
- rd_kind  out  2  entry kind.
- rd_addr  out  ADDR_WIDTH  entry address.
- rd_data  out  DATA_WIDTH  entry data.
- rd_last  out  1  final entry of the dump.
- state  out  2  FSM state.
- triggered  out  1  trigger has fired since arm.
- done  out  1  one-cycle pulse on entry to READ.
- entries  out  CW  valid entries held, saturates at DEPTH.
- drop_cnt  out  16  dropped fetches, saturating.

Behaviour:
- Reset: all outputs 0, state IDLE, pointers 0. Storage contents don't care. Reset mid-operation aborts immediately.
- Kinds: IFETCH=0 (data = idata), DLOAD=1 (data = ddata_r), DSTORE=2 (data = ddata_w).
- Capture candidate per cycle: a data access if mode[1] & d_valid; otherwise a fetch if mode[0] & i_valid.
- Simultaneous enabled fetch and data access: the data entry wins and drop_cnt increments (saturates at 0xFFFF).
- An entry is written at the rising edge where it is sampled. wr_ptr wraps modulo DEPTH. entries increments to DEPTH and holds there; the oldest entry is overwritten.
- IDLE:
  - arm -> ARMED.
  - Clears entries, wr_ptr, triggered and drop_cnt.
  - Nothing is captured in the arm cycle.
- ARMED:
  - Capture every candidate.
  - If the written entry's address == trig_addr, set triggered, load post counter = min(post_count, DEPTH-1), go to POST; if the loaded value is 0, go to READ instead.
- POST:
  - Each written entry decrements the counter.
  - The write that takes it to 0 moves the FSM to READ on that edge.
  - done pulses in the first READ cycle.
- READ:
  - No capture.
  - rd_ptr starts at (wr_ptr - entries) mod DEPTH.
  - rd_valid = 1; rd_* are combinational from storage[rd_ptr].
  - A transfer occurs on rd_valid & rd_ready: rd_ptr advances.
  - rd_last = 1 on the final entry; its transfer -> IDLE with rd_valid 0 next cycle.
  - rd_* must hold stable while rd_valid & !rd_ready.
- arm is ignored outside IDLE. mode and trig_addr changes outside IDLE take effect next cycle (no protection).
- entries == 0 in READ cannot occur, because the trigger entry is always recorded.
- Clamping post_count to DEPTH-1 guarantees the trigger entry survives in the dump.

Decomposition:
- Package core_trace_pkg holds:
  - state_t enum: IDLE=0, ARMED=1, POST=2, READ=3.
  - kind_t enum: IFETCH, DLOAD, DSTORE.
  - A parametrised entry struct {kind, addr, data}.
  - Width helper constants.
- One sub-module, trace_ring: storage array, write/read pointers and entries counter, with write-enable, read-advance and clear inputs.
- The FSM, capture arbitration and trigger logic stay in core_trace_capture.

Test Plan:
- DEPTH=8, mode=01, post_count=2, trig_addr=0x10:
  - Stimulus: arm, then fetches at 0x00, 0x04 … 0x1C.
  - Required: trigger at 0x10; READ after 0x18; dump 0x00…0x18 (7 entries), rd_last on 0x18, done pulses once.
- Wrap-around, mode=01, trig_addr=0x40, post_count=3:
  - Stimulus: fetches 0x00 … 0x4C.
  - Required: entries=8; dump 0x30…0x4C oldest-first, kinds all IFETCH.
- Conflict, mode=11:
  - Stimulus: i_valid and d_valid both high for 5 cycles, store d_rw=1, daddr=0x100, ddata_w=0xDEADBEEF, trig_addr=0x100, post_count=4.
  - Required: drop_cnt=5; dump 5 DSTORE entries with data 0xDEADBEEF.
- Backpressure:
  - Stimulus: toggle rd_ready 1/0 every cycle during the dump.
  - Required: rd_* stable while stalled; no entry skipped or duplicated; IDLE after the last transfer.
- Clamp:
  - Stimulus: post_count=15 with DEPTH=8.
  - Required: stops 7 entries after trigger; trigger entry is the first dumped.
  - Stimulus: post_count=0.
  - Required: READ the cycle after the trigger entry.
- Reset in POST:
  - Stimulus: assert RESET asynchronously between clock edges.
  - Required: state=IDLE, rd_valid=0, entries=0, triggered=0 immediately.
  - Stimulus: a later arm.
  - Required: a clean new capture.
